// File: rtl/cpu_pkg.sv
// Shared CPU-side constants and encodings for the data-memory responder.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

endpackage

// File: rtl/dm_array.sv
// Synchronous single-port storage array; read data stays registered until the next read.
module dm_array #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [0:(1 << DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store, stalls the pipeline
// for LATENCY cycles, then strobes rsp_valid with registered read data.
module dmem_responder #(
    parameter int unsigned ADDR_W     = cpu_pkg::ADDR_W,
    parameter int unsigned DATA_W     = cpu_pkg::DATA_W,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_re,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              busy,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    import cpu_pkg::*;

    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    op_t               cap_op;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic              enter_done;
    logic              rdata_ok;

    op_t               acc_op;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_oor;
    logic              arr_en;
    logic [DATA_W-1:0] arr_rdata;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        busy       = 1'b0;
        enter_done = 1'b0;
        case (state)
            IDLE: begin
                if (req_re | req_we) begin
                    busy = 1'b1;
                    if (LATENCY == 1) begin
                        state_nxt  = DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_nxt = BUSY;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt == 4'd0) begin
                    state_nxt  = DONE;
                    enter_done = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // With LATENCY==1 the DONE-entry edge is also the accept edge, so the array
    // is driven straight from the request rather than from the capture registers.
    always_comb begin
        if (state == IDLE) begin
            acc_op    = req_we ? OP_WR : OP_RD;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end else begin
            acc_op    = cap_op;
            acc_addr  = cap_addr;
            acc_wdata = cap_wdata;
        end
        acc_oor = (acc_addr >> DEPTH_LOG2) != '0;
        arr_en  = enter_done & ~acc_oor & rst_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cap_op    <= OP_RD;
            cap_addr  <= '0;
            cap_wdata <= '0;
            rsp_err   <= 1'b0;
            rdata_ok  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && (req_re | req_we)) begin
                cap_op    <= req_we ? OP_WR : OP_RD;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end
            if (enter_done) begin
                rsp_err <= acc_oor;
                if (acc_oor) begin
                    rdata_ok <= 1'b0;
                end else if (acc_op == OP_RD) begin
                    rdata_ok <= 1'b1;
                end
            end
        end
    end

    dm_array #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (acc_op == OP_WR),
        .addr  (acc_addr[DEPTH_LOG2-1:0]),
        .wdata (acc_wdata),
        .rdata (arr_rdata)
    );

    // The array output only changes on reads; masking it yields zero after
    // reset or an out-of-range completion, and holds across in-range writes.
    assign rsp_rdata = rdata_ok ? arr_rdata : '0;
    assign rsp_valid = (state == DONE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=3 and one LATENCY=1 instance.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        re    [2];
    logic        we    [2];
    logic [15:0] addr  [2];
    logic [15:0] wdata [2];
    logic        busy  [2];
    logic        valid [2];
    logic [15:0] rdata [2];
    logic        err   [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .ADDR_W (16), .DATA_W (16), .DEPTH_LOG2 (10), .LATENCY (3)
    ) dut3 (
        .clk (clk), .rst_n (rst_n),
        .req_re (re[0]), .req_we (we[0]), .req_addr (addr[0]), .req_wdata (wdata[0]),
        .busy (busy[0]), .rsp_valid (valid[0]), .rsp_rdata (rdata[0]), .rsp_err (err[0])
    );

    dmem_responder #(
        .ADDR_W (16), .DATA_W (16), .DEPTH_LOG2 (10), .LATENCY (1)
    ) dut1 (
        .clk (clk), .rst_n (rst_n),
        .req_re (re[1]), .req_we (we[1]), .req_addr (addr[1]), .req_wdata (wdata[1]),
        .busy (busy[1]), .rsp_valid (valid[1]), .rsp_rdata (rdata[1]), .rsp_err (err[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_all();
        for (int unsigned i = 0; i < 2; i++) begin
            re[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0;
        end
    endtask

    // Present a request just after a posedge (cycle 0) and check every cycle up to
    // the response. Returns just after the edge that ends the DONE cycle.
    task automatic txn(input int unsigned d, input int unsigned lat, input logic r, input logic w,
                       input logic [15:0] a, input logic [15:0] wd, input logic chk_data,
                       input logic [15:0] exp_data, input logic exp_err, input string tag);
        re[d] = r; we[d] = w; addr[d] = a; wdata[d] = wd;
        for (int unsigned k = 0; k <= lat; k++) begin
            @(negedge clk);
            check_eq({tag, "_busy"}, 32'(busy[d]), 32'(k < lat));
            check_eq({tag, "_valid"}, 32'(valid[d]), 32'(k == lat));
            if (k == lat) begin
                check_eq({tag, "_err"}, 32'(err[d]), 32'(exp_err));
                if (chk_data) check_eq({tag, "_rdata"}, 32'(rdata[d]), 32'(exp_data));
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        idle_all();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: idle after reset
        for (int unsigned c = 0; c < 10; c++) begin
            @(negedge clk);
            check_eq("t1_busy", 32'(busy[0]), 32'd0);
            check_eq("t1_valid", 32'(valid[0]), 32'd0);
            check_eq("t1_rdata", 32'(rdata[0]), 32'd0);
        end
        @(posedge clk); #1;

        // 2: store then back-to-back load
        txn(0, 3, 1'b0, 1'b1, 16'h0005, 16'hBEEF, 1'b1, 16'h0000, 1'b0, "t2_st");
        txn(0, 3, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b1, 16'hBEEF, 1'b0, "t2_ld");
        idle_all();
        @(negedge clk);
        check_eq("t2_idle_busy", 32'(busy[0]), 32'd0);
        @(posedge clk); #1;

        // 3: LATENCY=1 instance
        txn(1, 1, 1'b0, 1'b1, 16'h0007, 16'h1234, 1'b0, 16'h0000, 1'b0, "t3_st");
        txn(1, 1, 1'b1, 1'b0, 16'h0007, 16'h0000, 1'b1, 16'h1234, 1'b0, "t3_ld");
        idle_all();
        @(posedge clk); #1;

        // 4: out-of-range store must not alias onto word 0
        txn(0, 3, 1'b0, 1'b1, 16'h0000, 16'h0A0A, 1'b0, 16'h0000, 1'b0, "t4_st0");
        txn(0, 3, 1'b0, 1'b1, 16'h0400, 16'hFFFF, 1'b1, 16'h0000, 1'b1, "t4_oor");
        txn(0, 3, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "t4_oor_rd");
        txn(0, 3, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0A0A, 1'b0, "t4_ld0");

        // 5: re and we together act as a write
        txn(0, 3, 1'b1, 1'b1, 16'h0010, 16'h00AA, 1'b0, 16'h0000, 1'b0, "t5_both");
        txn(0, 3, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 16'h00AA, 1'b0, "t5_ld");

        // 6: reset in the middle of a store aborts it
        txn(0, 3, 1'b0, 1'b1, 16'h0020, 16'h1111, 1'b0, 16'h0000, 1'b0, "t6_pre");
        re[0] = 1'b0; we[0] = 1'b1; addr[0] = 16'h0020; wdata[0] = 16'h5555;
        @(negedge clk);
        check_eq("t6_c0_busy", 32'(busy[0]), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_valid", 32'(valid[0]), 32'd0);
        check_eq("t6_rst_rdata", 32'(rdata[0]), 32'd0);
        check_eq("t6_rst_err", 32'(err[0]), 32'd0);
        idle_all();
        for (int unsigned c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("t6_no_valid", 32'(valid[0]), 32'd0);
            if (c == 2) rst_n = 1'b1;
        end
        @(posedge clk); #1;
        txn(0, 3, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h1111, 1'b0, "t6_ld");
        idle_all();
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
